display_inspector: RTL

- Downstream consumer of the computer top level's debug read ports: register file, data RAM, instruction ROM, PC.
- Drives one shared 6-bit display address into all three display address ports, waits out the synchronous read latency, then captures the selected 32-bit value.
- Renders the captured value as eight active-low seven-segment hex digits for the board.
- Supports manual inspection from switches and an auto-scan mode that walks addresses 0..63, with periodic refresh so live values track execution.

---
 rtl/display_inspector.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/display_inspector.sv
// display_inspector: reads one word from the computer's debug read ports
// (register file, data RAM, instruction ROM or PC), holds it and renders it
// as eight active-low seven-segment hex digits.
//
// Sequence: ISSUE drives the shared display address, WAIT covers the memories'
// synchronous read latency, CAPTURE samples the selected word and updates the
// digits on the same edge, and HOLD keeps it on screen for DWELL_CYCLES before
// a refresh (manual mode) or an advance to the next address (auto-scan).
// In manual mode HOLD also exits as soon as the switches disagree with what
// is on screen, so the display follows the switches without waiting a dwell.
//
// Handshake: there is no valid/ready pair. The read ports are fire-and-forget
// with a fixed latency: display_address is stable from the ISSUE edge until
// the next ISSUE, and the *_value inputs are assumed valid READ_LATENCY clocks
// after it changes. 'valid' only states that captured_* hold a real sample.
module display_inspector #(
  parameter int READ_LATENCY = 2,        // 1..7 clocks from address to data
  parameter int DWELL_CYCLES = 50000000  // >= 1 clocks a capture is held
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  source_select,
  input  logic [5:0]  manual_address,
  input  logic        auto_scan,
  input  logic [31:0] register_value,
  input  logic [31:0] data_value,
  input  logic [31:0] instruction_value,
  input  logic [31:0] pc_value,
  output logic [5:0]  display_address,
  output logic [31:0] captured_value,
  output logic [5:0]  captured_address,
  output logic [1:0]  captured_source,
  output logic        valid,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic [1:0]  state_debug
);

  // Dwell counter only needs to reach DWELL_CYCLES-1.
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [2:0]    WAIT_LAST  = 3'(READ_LATENCY - 1);
  localparam logic [6:0]    SEG_ZERO   = 7'b1000000;

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [2:0]      wait_count;
  logic [DW-1:0]   dwell_count;
  logic [5:0]      scan_address;
  logic [5:0]      target_address;
  logic [1:0]      target_source;
  logic [31:0]     selected_value;

  logic            wait_done;
  logic            dwell_done;
  logic            switches_differ;
  logic            issue_en;
  logic            capture_en;
  logic            scan_advance;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_segments(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = SEG_ZERO;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_ZERO;
    endcase
    return seg;
  endfunction

  assign wait_done   = (wait_count == WAIT_LAST);
  assign dwell_done  = (dwell_count == DWELL_LAST);
  assign state_debug = state;

  // Manual-mode switches no longer match the word on screen.
  assign switches_differ = !auto_scan &&
                           ((manual_address != captured_address) ||
                            (source_select  != captured_source));

  // Word selected by the source latched at ISSUE (not the live switches).
  always_comb begin
    selected_value = register_value;
    case (target_source)
      2'b00:   selected_value = register_value;
      2'b01:   selected_value = data_value;
      2'b10:   selected_value = instruction_value;
      2'b11:   selected_value = pc_value;
      default: selected_value = register_value;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_ISSUE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_ISSUE:   state_next = ST_WAIT;
      ST_WAIT:    if (wait_done) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_HOLD;
      ST_HOLD:    if (dwell_done || switches_differ) state_next = ST_ISSUE;
      default:    state_next = ST_ISSUE;
    endcase
  end

  // Per-state control strobes for the datapath.
  always_comb begin
    issue_en     = 1'b0;
    capture_en   = 1'b0;
    scan_advance = 1'b0;
    case (state)
      ST_ISSUE:   issue_en     = 1'b1;
      ST_CAPTURE: capture_en   = 1'b1;
      ST_HOLD:    scan_advance = dwell_done && auto_scan;
      default:    ;
    endcase
  end

  // Read-latency and dwell counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_count  <= '0;
      dwell_count <= '0;
    end else begin
      if (issue_en)
        wait_count <= '0;
      else if (state == ST_WAIT && !wait_done)
        wait_count <= wait_count + 3'd1;

      if (capture_en)
        dwell_count <= '0;
      else if (state == ST_HOLD && !dwell_done)
        dwell_count <= dwell_count + DW'(1);
    end
  end

  // Scan address survives mode changes; it only moves on a dwell expiry in auto mode.
  always_ff @(posedge clock) begin
    if (reset)             scan_address <= '0;
    else if (scan_advance) scan_address <= scan_address + 6'd1;
  end

  // Target latch and display address: only ISSUE may move the read port address.
  always_ff @(posedge clock) begin
    if (reset) begin
      target_address  <= '0;
      target_source   <= '0;
      display_address <= '0;
    end else if (issue_en) begin
      target_address  <= auto_scan ? scan_address : manual_address;
      target_source   <= source_select;
      display_address <= auto_scan ? scan_address : manual_address;
    end
  end

  // Capture the word and redraw all digits on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      captured_value   <= '0;
      captured_address <= '0;
      captured_source  <= '0;
      valid            <= 1'b0;
      HEX0 <= SEG_ZERO;
      HEX1 <= SEG_ZERO;
      HEX2 <= SEG_ZERO;
      HEX3 <= SEG_ZERO;
      HEX4 <= SEG_ZERO;
      HEX5 <= SEG_ZERO;
      HEX6 <= SEG_ZERO;
      HEX7 <= SEG_ZERO;
    end else if (capture_en) begin
      captured_value   <= selected_value;
      captured_address <= target_address;
      captured_source  <= target_source;
      valid            <= 1'b1;
      HEX0 <= hex_segments(selected_value[3:0]);
      HEX1 <= hex_segments(selected_value[7:4]);
      HEX2 <= hex_segments(selected_value[11:8]);
      HEX3 <= hex_segments(selected_value[15:12]);
      HEX4 <= hex_segments(selected_value[19:16]);
      HEX5 <= hex_segments(selected_value[23:20]);
      HEX6 <= hex_segments(selected_value[27:24]);
      HEX7 <= hex_segments(selected_value[31:28]);
    end
  end

endmodule
